// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: issues one operation at a time to the combinational ALU
// or the NPU, and returns the result, zero flag, tag and error on a valid/ready port.
module alu_exec_ctrl #(
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 5,
    parameter int MUL_CYCLES  = 3,
    parameter int NPU_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              npu_req,
    output logic [DATA_W-1:0] npu_a,
    output logic [DATA_W-1:0] npu_b,
    input  logic              npu_ack,
    input  logic [DATA_W-1:0] npu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam logic [3:0] OP_MUL    = 4'b1010;
    localparam logic [3:0] OP_CUSTOM = 4'b1111;
    localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int NCW = $clog2(NPU_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, EXEC, MULW, NPUW, DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_op;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [TAG_W-1:0]   r_tag;
    logic [MCW-1:0]     r_mul_cnt;
    logic [NCW-1:0]     r_npu_cnt;
    logic [DATA_W-1:0]  r_out_result;
    logic               r_out_zero;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_out_err;

    logic w_accept;
    logic w_illegal;
    logic w_npu_timeout;

    assign in_ready      = (r_state == IDLE) && rst_n;
    assign w_accept      = in_valid && in_ready;
    assign w_illegal     = (r_op >= 4'b1011) && (r_op <= 4'b1110);
    // Timeout fires on the NPU_TIMEOUT-th cycle spent waiting in NPUW
    assign w_npu_timeout = (r_npu_cnt == NCW'(NPU_TIMEOUT - 1));

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_op     = r_op;
    assign npu_req    = (r_state == NPUW);
    assign npu_a      = (r_state == NPUW) ? r_a : '0;
    assign npu_b      = (r_state == NPUW) ? r_b : '0;
    assign out_valid  = (r_state == DONE);
    assign out_result = r_out_result;
    assign out_zero   = r_out_zero;
    assign out_tag    = r_out_tag;
    assign out_err    = r_out_err;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_op == OP_CUSTOM)   w_state_next = NPUW;
                    else if (in_op == OP_MUL) w_state_next = MULW;
                    else                      w_state_next = EXEC;
                end
            end
            EXEC:    w_state_next = DONE;
            MULW:    if (r_mul_cnt == '0) w_state_next = DONE;
            NPUW:    if (npu_ack || w_npu_timeout) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_tag        <= '0;
            r_mul_cnt    <= '0;
            r_npu_cnt    <= '0;
            r_out_result <= '0;
            r_out_zero   <= 1'b1;
            r_out_tag    <= '0;
            r_out_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state != DONE && w_state_next == DONE) begin
                r_out_tag <= r_tag;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op      <= in_op;
                        r_a       <= in_a;
                        r_b       <= in_b;
                        r_tag     <= in_tag;
                        r_mul_cnt <= MCW'(MUL_CYCLES - 1);
                        r_npu_cnt <= '0;
                    end
                end
                EXEC: begin
                    if (w_illegal) begin
                        r_out_result <= '0;
                        r_out_zero   <= 1'b1;
                        r_out_err    <= 1'b1;
                    end else begin
                        r_out_result <= alu_result;
                        r_out_zero   <= alu_zero;
                        r_out_err    <= 1'b0;
                    end
                end
                MULW: begin
                    if (r_mul_cnt != '0) begin
                        r_mul_cnt <= r_mul_cnt - MCW'(1);
                    end else begin
                        r_out_result <= alu_result;
                        r_out_zero   <= alu_zero;
                        r_out_err    <= 1'b0;
                    end
                end
                NPUW: begin
                    // An ack arriving on the timeout cycle still delivers its result
                    if (npu_ack) begin
                        r_out_result <= npu_result;
                        r_out_zero   <= (npu_result == '0);
                        r_out_err    <= 1'b0;
                    end else if (w_npu_timeout) begin
                        r_out_result <= '0;
                        r_out_zero   <= 1'b1;
                        r_out_err    <= 1'b1;
                    end else begin
                        r_npu_cnt <= r_npu_cnt + NCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
